adder64_seq_ctrl: RTL and testbench

- Sequencer that computes a 64-bit add/subtract by time-multiplexing one 16-bit ripple adder slice (FullAdder16bit) over 4 cycles.
- A registered carry links the slices, least-significant slice first.
- Trades latency for area against the fully combinational 64-bit chain.
- Sits between the ALU issue logic (valid/ready request side) and the writeback logic (valid/ready result side).

---
 rtl/adder64_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_adder64_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder64_seq_ctrl.sv
// adder64_seq_ctrl: 64-bit add/subtract built from one shared 16-bit ripple
// slice. The slice is used once per cycle, least-significant slice first.
// A registered carry links consecutive passes. A request is accepted on a
// valid/ready handshake and the result is held until the consumer takes it.

// Shared combinational slice: 16-bit ripple-carry adder, no internal state.
module FullAdder16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [16:0] carry_s;

   // Ripple the carry bit by bit through the slice.
   always_comb begin
      carry_s    = 17'd0;
      sum        = 16'd0;
      carry_s[0] = cin;
      for (int i = 0; i < 16; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
      end
      cout = carry_s[16];
   end

endmodule

module adder64_seq_ctrl #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               carry_r;
   // The operand registers shift right one slice per pass. The active slice
   // therefore always sits in the low SLICE bits. On the last pass, bit
   // SLICE-1 holds the operand MSB that the overflow check needs.
   logic [WIDTH-1:0]   a_sh_r;
   logic [WIDTH-1:0]   b_sh_r;
   logic [WIDTH-1:0]   s_r;
   logic               cout_r;
   logic               ovf_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic               busy_r;

   logic [SLICE-1:0]   slice_sum_s;
   logic               slice_cout_s;

   FullAdder16bit u_slice (
      .a    (a_sh_r[SLICE-1:0]),
      .b    (b_sh_r[SLICE-1:0]),
      .cin  (carry_r),
      .sum  (slice_sum_s),
      .cout (slice_cout_s)
   );

   // Controller FSM: accepts requests, runs the slice passes, holds the
   // result and generates the registered handshake and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         carry_r     <= 1'b0;
         a_sh_r      <= '0;
         b_sh_r      <= '0;
         s_r         <= '0;
         cout_r      <= 1'b0;
         ovf_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && in_ready_r) begin
                  a_sh_r     <= A;
                  // Subtraction is A + ~B + 1, so Cin is ignored when Sub=1.
                  b_sh_r     <= Sub ? ~B : B;
                  carry_r    <= Sub ? 1'b1 : Cin;
                  s_r        <= '0;
                  cnt_r      <= '0;
                  state_r    <= ST_RUN;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            ST_RUN: begin
               for (int k = 0; k < NSLICE; k++) begin
                  if (cnt_r == CNT_W'(k)) begin
                     s_r[k*SLICE +: SLICE] <= slice_sum_s;
                  end
               end
               carry_r <= slice_cout_s;
               a_sh_r  <= a_sh_r >> SLICE;
               b_sh_r  <= b_sh_r >> SLICE;
               if (cnt_r == LAST_CNT) begin
                  cnt_r       <= '0;
                  cout_r      <= slice_cout_s;
                  // Overflow: the operand signs agree and the result sign differs.
                  ovf_r       <= (a_sh_r[SLICE-1] ~^ b_sh_r[SLICE-1]) &
                                 (slice_sum_s[SLICE-1] ^ a_sh_r[SLICE-1]);
                  state_r     <= ST_DONE;
                  busy_r      <= 1'b0;
                  out_valid_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= '0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign S         = s_r;
   assign Cout      = cout_r;
   assign Ovf       = ovf_r;

endmodule

// File: tb/tb_adder64_seq_ctrl.sv
// Testbench for adder64_seq_ctrl. Directed corner cases and random operations
// are checked against a plain-arithmetic model of 64-bit add/subtract.
module tb_adder64_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] A;
   logic [63:0] B;
   logic        Cin;
   logic        Sub;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] S;
   logic        Cout;
   logic        Ovf;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   adder64_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .Sub       (Sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .Ovf       (Ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: unsigned 65-bit arithmetic for S and Cout.
   // Signed range check for Ovf.
   task automatic model(input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic sub,
                        output logic [63:0] s, output logic co, output logic ov);
      logic [64:0]        u;
      logic signed [65:0] r;
      logic signed [65:0] smax;
      logic signed [65:0] smin;
      smax = {3'b000, {63{1'b1}}};
      smin = {3'b111, 63'd0};
      if (sub) begin
         u  = {1'b0, a} - {1'b0, b};
         co = (a >= b);
         r  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
      end else begin
         u  = {1'b0, a} + {1'b0, b} + {64'd0, c};
         co = u[64];
         r  = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, c});
      end
      s  = u[63:0];
      ov = (r > smax) || (r < smin);
   endtask

   // Issue one request, wait (bounded) for the result and report it with its latency.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic sub,
                         output logic [63:0] s, output logic co, output logic ov,
                         output int lat);
      int w;
      A = a; B = b; Cin = c; Sub = sub; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = {$urandom, $urandom}; B = {$urandom, $urandom};
      Cin = 1'($urandom); Sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      s = S; co = Cout; ov = Ovf;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (S !== 64'd0) begin miscompares++; $display("FAIL reset_S got %h want 0", S); end
      vectors++; if (Cout !== 1'b0) begin miscompares++; $display("FAIL reset_Cout got %b want 0", Cout); end
      vectors++; if (Ovf !== 1'b0) begin miscompares++; $display("FAIL reset_Ovf got %b want 0", Ovf); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      rst = 1'b0;
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_full_ripple();
      logic [63:0] s; logic co, ov; int lat;
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, s, co, ov, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL ripple_latency got %0d want 4", lat); end
      vectors++; if (s !== 64'd0) begin miscompares++; $display("FAIL ripple_S got %h want 0", s); end
      vectors++; if (co !== 1'b1) begin miscompares++; $display("FAIL ripple_Cout got %b want 1", co); end
      vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL ripple_Ovf got %b want 0", ov); end
      release_result();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ripple_out_valid_drop got %b want 0", out_valid); end
   endtask

   task automatic test_signed_ovf();
      logic [63:0] s; logic co, ov; int lat;
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, s, co, ov, lat);
      vectors++; if (s !== 64'h8000_0000_0000_0000) begin miscompares++; $display("FAIL ovf_S got %h want 8000000000000000", s); end
      vectors++; if (co !== 1'b0) begin miscompares++; $display("FAIL ovf_Cout got %b want 0", co); end
      vectors++; if (ov !== 1'b1) begin miscompares++; $display("FAIL ovf_Ovf got %b want 1", ov); end
      release_result();
   endtask

   task automatic test_sub_borrow();
      logic [63:0] s; logic co, ov; int lat;
      run_op(64'd5, 64'd7, 1'b0, 1'b1, s, co, ov, lat);
      vectors++; if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin miscompares++; $display("FAIL sub57_S got %h want fffffffffffffffe", s); end
      vectors++; if (co !== 1'b0) begin miscompares++; $display("FAIL sub57_Cout got %b want 0", co); end
      vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL sub57_Ovf got %b want 0", ov); end
      release_result();
      run_op(64'd7, 64'd5, 1'b0, 1'b1, s, co, ov, lat);
      vectors++; if (s !== 64'd2) begin miscompares++; $display("FAIL sub75_S got %h want 2", s); end
      vectors++; if (co !== 1'b1) begin miscompares++; $display("FAIL sub75_Cout got %b want 1", co); end
      release_result();
   endtask

   task automatic test_cross_slice();
      logic [63:0] s; logic co, ov; int lat;
      run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b1, 1'b0, s, co, ov, lat);
      vectors++; if (s !== 64'h0000_0000_0001_0001) begin miscompares++; $display("FAIL cross_S got %h want 10001", s); end
      vectors++; if (co !== 1'b0) begin miscompares++; $display("FAIL cross_Cout got %b want 0", co); end
      release_result();
   endtask

   task automatic test_reset_mid_run();
      int w;
      logic seen;
      A = 64'd1; B = 64'd1; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
      vectors++; if (S !== 64'd0) begin miscompares++; $display("FAIL midrst_S got %h want 0", S); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
      #2;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_spurious_valid got %b want 0", seen); end
   endtask

   task automatic test_random();
      logic [63:0] a, b, s, es;
      logic c, sub, co, ov, eco, eov;
      int lat;
      for (int n = 0; n < 24; n++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = ~a;
            2: a[62:0] = {63{a[63]}};
            default: ;
         endcase
         c = 1'($urandom); sub = 1'($urandom);
         model(a, b, c, sub, es, eco, eov);
         run_op(a, b, c, sub, s, co, ov, lat);
         vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rand_latency[%0d] got %0d want 4", n, lat); end
         vectors++; if (s !== es || co !== eco || ov !== eov)
            begin miscompares++; $display("FAIL rand_result[%0d] a=%h b=%h c=%b sub=%b got S=%h C=%b V=%b want S=%h C=%b V=%b",
                                          n, a, b, c, sub, s, co, ov, es, eco, eov); end
         release_result();
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] a1, b1, a2, b2, s, es, held;
      logic c2, co, ov, eco, eov;
      int lat;
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; c2 = 1'($urandom);
      run_op(a1, b1, 1'b1, 1'b0, s, co, ov, lat);
      held = S;
      A = a2; B = b2; Cin = c2; Sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         vectors++; if (S !== held || out_valid !== 1'b1 || in_ready !== 1'b0)
            begin miscompares++; $display("FAIL stall[%0d] got S=%h ov=%b ir=%b want S=%h ov=1 ir=0",
                                          i, S, out_valid, in_ready, held); end
      end
      release_result();
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin miscompares++; $display("FAIL b2b_idle got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++; if (busy !== 1'b1 || in_ready !== 1'b0)
         begin miscompares++; $display("FAIL b2b_accept got busy=%b ir=%b want busy=1 ir=0", busy, in_ready); end
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      model(a2, b2, c2, 1'b0, es, eco, eov);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL b2b_latency got %0d want 4", lat); end
      vectors++; if (S !== es || Cout !== eco || Ovf !== eov)
         begin miscompares++; $display("FAIL b2b_result got S=%h C=%b V=%b want S=%h C=%b V=%b",
                                       S, Cout, Ovf, es, eco, eov); end
      release_result();
   endtask

   initial begin
      test_reset();
      test_full_ripple();
      test_signed_ovf();
      test_sub_borrow();
      test_cross_slice();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
